// File: rtl/fetch_aligner.sv
// Fetch aligner: walks a halfword-addressed program memory and hands
// aligned 16/32-bit instructions to decode over a valid/ready bundle.
module fetch_aligner #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_BYTES = 2048
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        dec_ready,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        if_compressed,
   output logic        halted
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [31:0] pc;
   logic [31:0] redir_tgt;
   logic        is_comp;
   logic [2:0]  isize;
   logic [32:0] pc_end;
   logic        illegal;
   logic        over_bound;
   logic        halt_cond;
   logic        capture;

   assign mem_addr   = pc;
   assign redir_tgt  = redirect_pc & ~32'h1;
   assign is_comp    = mem_rdata[1:0] != 2'b11;
   assign isize      = is_comp ? 3'd2 : 3'd4;
   // One extra bit so a fetch near 2^32 cannot wrap past the bound check
   assign pc_end     = {1'b0, pc} + {30'd0, isize};
   assign illegal    = mem_rdata[15:0] == 16'h0000;
   assign over_bound = pc_end > 33'(MEM_BYTES);
   assign halt_cond  = illegal || over_bound;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = RUN;
         RUN: begin
            if (redirect_valid) begin
               state_nx = RUN;
            end else if (halt_cond) begin
               state_nx = HALT;
            end
         end
         HALT: begin
            if (redirect_valid) begin
               state_nx = RUN;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      halted  = 1'b0;
      capture = 1'b0;
      case (state)
         RUN: begin
            capture = !redirect_valid && !halt_cond
                      && (!if_valid || dec_ready);
         end
         HALT: halted = 1'b1;
         default: begin
            halted  = 1'b0;
            capture = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc            <= RESET_PC;
         if_valid      <= 1'b0;
         if_instr      <= '0;
         if_pc         <= '0;
         if_compressed <= 1'b0;
      end else begin
         if (redirect_valid) begin
            pc <= redir_tgt;
         end else if (capture) begin
            pc <= pc + {29'd0, isize};
         end
         // A redirect flushes the bundle even if decode is taking it
         if (redirect_valid) begin
            if_valid <= 1'b0;
         end else if (capture) begin
            if_valid <= 1'b1;
         end else if (dec_ready) begin
            if_valid <= 1'b0;
         end
         if (capture) begin
            if_instr      <= is_comp ? {16'h0000, mem_rdata[15:0]}
                                     : mem_rdata;
            if_pc         <= pc;
            if_compressed <= is_comp;
         end
      end
   end

endmodule
